// File: rtl/log_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// log_arbiter_pkg
// Shared constants for the frontpanel logging path: the host write address
// that programs the per-channel logging enables, the default log channel and
// data widths, and the packed layout of one word on the serialized log bus.
// No ports (package).
// ---------------------------------------------------------------------------
package log_arbiter_pkg;

    localparam int W_LCHAN = 5;
    localparam int W_LDATA = 18;

    // Host write addresses. The logging-enable request sits directly after
    // the pipe channel-set request in the address map.
    localparam logic [15:0] PIPE_CSET_RQST = 16'h0080;
    localparam logic [15:0] LOG_EN_RQST    = PIPE_CSET_RQST + 16'd1;

    // One word as seen by consumers of the log bus.
    typedef struct packed {
        logic [W_LCHAN-1:0] chan;
        logic [W_LDATA-1:0] data;
    } log_word_t;

endpackage

// File: rtl/log_arbiter_if.sv
// ---------------------------------------------------------------------------
// log_arbiter_if
// Bundles the oversample-filter inputs, the host write bus and the serialized
// log bus of log_arbiter.
//   osf_dv_in/osf_data_in   per-channel strobes and packed data words
//   wr_*_in                 host write bus (enable programming)
//   log_dv/chan/data_out    serialized log bus
//   log_en_out              current channel enable mask
//   drop_count_out          saturating count of overwritten words
// Modports: master drives the inputs and observes the outputs (producer /
// host side); slave is the arbiter itself.
// ---------------------------------------------------------------------------
interface log_arbiter_if #(
    parameter int N_LOG     = 8,
    parameter int W_LCHAN   = log_arbiter_pkg::W_LCHAN,
    parameter int W_LDATA   = log_arbiter_pkg::W_LDATA,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 5,
    parameter int W_WR_DATA = 49,
    parameter int W_DROP    = 16
);

    logic [N_LOG-1:0]         osf_dv_in;
    logic [N_LOG*W_LDATA-1:0] osf_data_in;
    logic                     wr_en_in;
    logic [W_WR_ADDR-1:0]     wr_addr_in;
    logic [W_WR_CHAN-1:0]     wr_chan_in;
    logic [W_WR_DATA-1:0]     wr_data_in;
    logic                     log_dv_out;
    logic [W_LCHAN-1:0]       log_chan_out;
    logic [W_LDATA-1:0]       log_data_out;
    logic [N_LOG-1:0]         log_en_out;
    logic [W_DROP-1:0]        drop_count_out;

    modport master (
        output osf_dv_in, osf_data_in, wr_en_in, wr_addr_in, wr_chan_in, wr_data_in,
        input  log_dv_out, log_chan_out, log_data_out, log_en_out, drop_count_out
    );

    modport slave (
        input  osf_dv_in, osf_data_in, wr_en_in, wr_addr_in, wr_chan_in, wr_data_in,
        output log_dv_out, log_chan_out, log_data_out, log_en_out, drop_count_out
    );

endinterface

// File: rtl/log_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// log_arbiter_rr_pick
// Combinational round-robin picker: finds the first set bit of pending_i
// searching cyclically upward from rr_ptr_i.
//   pending_i      request mask, bit k = channel k
//   rr_ptr_i       search start index (must be < N)
//   grant_valid_o  at least one request present
//   grant_idx_o    winning channel index
// Implementation: rotate the mask so rr_ptr_i lands on bit 0, take the
// lowest set bit, then add rr_ptr_i back modulo N.
// ---------------------------------------------------------------------------
module log_arbiter_rr_pick #(
    parameter int N     = 8,
    parameter int W_IDX = 5
) (
    input  logic [N-1:0]     pending_i,
    input  logic [W_IDX-1:0] rr_ptr_i,
    output logic             grant_valid_o,
    output logic [W_IDX-1:0] grant_idx_o
);

    logic [N-1:0]     rot;
    logic [W_IDX-1:0] pos;
    logic [W_IDX:0]   sum;

    // Doubling the mask makes the right shift a rotate for any pointer < N.
    assign rot = N'({pending_i, pending_i} >> rr_ptr_i);

    always_comb begin
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = W_IDX'(i);
            end
        end
    end

    assign sum           = {1'b0, pos} + {1'b0, rr_ptr_i};
    assign grant_valid_o = |pending_i;

    always_comb begin
        if (sum >= (W_IDX + 1)'(N)) begin
            grant_idx_o = W_IDX'(sum - (W_IDX + 1)'(N));
        end else begin
            grant_idx_o = sum[W_IDX-1:0];
        end
    end

endmodule

// File: rtl/log_arbiter.sv
// ---------------------------------------------------------------------------
// log_arbiter
// Collects one pending oversample-filter word per channel and serializes the
// words round-robin onto a single log bus feeding the wire-out registers and
// the block-mode pipe FIFO. Per-channel logging enables are programmed over
// the host write bus at LOG_EN_RQST.
//   pid_clk_in  system clock (rising edge)
//   rst_in      synchronous active-high reset
//   bus         log_arbiter_if.slave: osf strobes/data, host write bus,
//               log_dv/chan/data, enable mask and drop counter outputs
// A word captured on one edge can be granted on the next edge, so an
// isolated strobe appears on the log bus two cycles after it is presented.
// ---------------------------------------------------------------------------
module log_arbiter #(
    parameter int N_LOG     = 8,
    parameter int W_LCHAN   = log_arbiter_pkg::W_LCHAN,
    parameter int W_LDATA   = log_arbiter_pkg::W_LDATA,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 5,
    parameter int W_WR_DATA = 49,
    parameter int W_DROP    = 16
) (
    input  logic          pid_clk_in,
    input  logic          rst_in,
    log_arbiter_if.slave  bus
);

    import log_arbiter_pkg::*;

    localparam int W_CNT = $clog2(N_LOG + 1);

    // Saturating add of a per-cycle drop count onto the running counter.
    function automatic logic [W_DROP-1:0] sat_add(input logic [W_DROP-1:0] a,
                                                  input logic [W_CNT-1:0]  n);
        logic [W_DROP:0] s;
        s = {1'b0, a} + (W_DROP + 1)'(n);
        return s[W_DROP] ? {W_DROP{1'b1}} : s[W_DROP-1:0];
    endfunction

    logic [N_LOG-1:0]   log_en_q,  log_en_d;
    logic [N_LOG-1:0]   pending_q, pending_d;
    logic [W_LDATA-1:0] hold_q [N_LOG];
    logic [W_LDATA-1:0] hold_d [N_LOG];
    logic [W_LCHAN-1:0] rr_ptr_q,  rr_ptr_d;
    logic [W_DROP-1:0]  drop_q,    drop_d;
    logic               log_dv_q,  log_dv_d;
    logic [W_LCHAN-1:0] log_chan_q, log_chan_d;
    logic [W_LDATA-1:0] log_data_q, log_data_d;

    logic               wr_hit;
    logic [N_LOG-1:0]   cap;
    logic [N_LOG-1:0]   gmask;
    logic [N_LOG-1:0]   drops;
    logic [W_CNT-1:0]   ndrop;
    logic [W_LDATA-1:0] grant_word;
    logic               grant_valid;
    logic [W_LCHAN-1:0] grant_idx;

    // Only bit 0 of the host write data carries the enable value.
    logic unused_wr_data;
    assign unused_wr_data = ^bus.wr_data_in[W_WR_DATA-1:1];

    log_arbiter_rr_pick #(
        .N     (N_LOG),
        .W_IDX (W_LCHAN)
    ) u_rr_pick (
        .pending_i     (pending_q),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // Enable update comes first so a capture in the same cycle sees it.
    always_comb begin
        wr_hit = bus.wr_en_in
              && (bus.wr_addr_in == W_WR_ADDR'(LOG_EN_RQST))
              && (int'(bus.wr_chan_in) < N_LOG);
        log_en_d = log_en_q;
        for (int k = 0; k < N_LOG; k++) begin
            if (wr_hit && (bus.wr_chan_in == W_WR_CHAN'(k))) begin
                log_en_d[k] = bus.wr_data_in[0];
            end
        end
    end

    always_comb begin
        cap   = bus.osf_dv_in & log_en_d;
        gmask = '0;
        for (int k = 0; k < N_LOG; k++) begin
            gmask[k] = grant_valid && (grant_idx == W_LCHAN'(k));
        end
        // Recapture on the granted channel keeps it pending; disabling clears.
        pending_d = ((pending_q & ~gmask) | cap) & log_en_d;
        // Overwrite of a still-pending word that is not leaving this cycle.
        drops = cap & pending_q & ~gmask;
        ndrop = '0;
        for (int k = 0; k < N_LOG; k++) begin
            ndrop = ndrop + W_CNT'(drops[k]);
        end
        drop_d = sat_add(drop_q, ndrop);
    end

    always_comb begin
        hold_d = hold_q;
        for (int k = 0; k < N_LOG; k++) begin
            if (cap[k]) begin
                hold_d[k] = bus.osf_data_in[k*W_LDATA +: W_LDATA];
            end
        end
    end

    // Output word is taken from the held value before this edge's capture.
    always_comb begin
        grant_word = '0;
        for (int k = 0; k < N_LOG; k++) begin
            if (gmask[k]) begin
                grant_word = hold_q[k];
            end
        end
        log_dv_d   = grant_valid;
        log_chan_d = log_chan_q;
        log_data_d = log_data_q;
        rr_ptr_d   = rr_ptr_q;
        if (grant_valid) begin
            log_chan_d = grant_idx;
            log_data_d = grant_word;
            if (grant_idx == W_LCHAN'(N_LOG - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + W_LCHAN'(1);
            end
        end
    end

    always_ff @(posedge pid_clk_in) begin
        if (rst_in) begin
            log_en_q   <= '1;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            drop_q     <= '0;
            log_dv_q   <= 1'b0;
            log_chan_q <= '0;
            log_data_q <= '0;
            for (int k = 0; k < N_LOG; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            log_en_q   <= log_en_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_q     <= drop_d;
            log_dv_q   <= log_dv_d;
            log_chan_q <= log_chan_d;
            log_data_q <= log_data_d;
            for (int k = 0; k < N_LOG; k++) begin
                hold_q[k] <= hold_d[k];
            end
        end
    end

    assign bus.log_dv_out     = log_dv_q;
    assign bus.log_chan_out   = log_chan_q;
    assign bus.log_data_out   = log_data_q;
    assign bus.log_en_out     = log_en_q;
    assign bus.drop_count_out = drop_q;

endmodule

// File: tb/tb_log_arbiter.sv
// ---------------------------------------------------------------------------
// tb_log_arbiter
// Directed bench for log_arbiter. Expected log words are queued as stimulus
// is driven and popped by a monitor whenever log_dv_out is seen; directed
// checks cover latency, ordering, drops, saturation, enables and reset.
// ---------------------------------------------------------------------------
module tb_log_arbiter;

    import log_arbiter_pkg::*;

    localparam int LD = 18;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    log_word_t exp_q[$];
    log_word_t e;

    log_arbiter_if bus ();

    log_arbiter dut (
        .pid_clk_in (clk),
        .rst_in     (rst),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int k, input logic [LD-1:0] d);
        bus.osf_data_in[k*LD +: LD] = d;
    endtask

    task automatic push(input int k, input logic [LD-1:0] d);
        log_word_t w;
        w.chan = 5'(k);
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic host_wr(input int ch, input logic v, input logic [15:0] addr);
        bus.wr_en_in   = 1'b1;
        bus.wr_addr_in = addr;
        bus.wr_chan_in = 5'(ch);
        bus.wr_data_in = 49'(v);
    endtask

    task automatic idle();
        bus.osf_dv_in = '0;
        bus.wr_en_in  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.log_dv_out === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed chan=%0d data=%h expected no word",
                       bus.log_chan_out, bus.log_data_out);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_chan", 32'(bus.log_chan_out), 32'(e.chan));
                check("sb_data", 32'(bus.log_data_out), 32'(e.data));
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.osf_dv_in   = '0;
        bus.osf_data_in = '0;
        bus.wr_en_in    = 1'b0;
        bus.wr_addr_in  = '0;
        bus.wr_chan_in  = '0;
        bus.wr_data_in  = '0;
        tick();
        tick();
        check("rst_dv",   32'(bus.log_dv_out),     32'h0);
        check("rst_chan", 32'(bus.log_chan_out),   32'h0);
        check("rst_data", 32'(bus.log_data_out),   32'h0);
        check("rst_en",   32'(bus.log_en_out),     32'hFF);
        check("rst_drop", 32'(bus.drop_count_out), 32'h0);
        rst = 1'b0;

        // Single strobe on ch3: two-cycle latency, one-cycle pulse.
        set_word(3, 18'h1ABCD);
        bus.osf_dv_in = 8'h08;
        push(3, 18'h1ABCD);
        tick();
        idle();
        check("t1_not_yet", 32'(bus.log_dv_out), 32'h0);
        tick();
        check("t1_dv",   32'(bus.log_dv_out),   32'h1);
        check("t1_chan", 32'(bus.log_chan_out), 32'h3);
        check("t1_data", 32'(bus.log_data_out), 32'h1ABCD);
        tick();
        check("t1_pulse", 32'(bus.log_dv_out), 32'h0);

        // All eight channels at once drain in order 0..7.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_word(k, 18'(32'h100 + k));
            push(k, 18'(32'h100 + k));
        end
        bus.osf_dv_in = 8'hFF;
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_dv",   32'(bus.log_dv_out),   32'h1);
            check("t2_chan", 32'(bus.log_chan_out), 32'(i));
        end
        tick();
        check("t2_idle", 32'(bus.log_dv_out),     32'h0);
        check("t2_drop", 32'(bus.drop_count_out), 32'h0);

        // Move rr_ptr to 6 via ch5, then ch1+ch7 pending: ch7 first.
        set_word(5, 18'h00055);
        bus.osf_dv_in = 8'h20;
        push(5, 18'h00055);
        tick();
        idle();
        tick();
        set_word(1, 18'h00111);
        set_word(7, 18'h00777);
        bus.osf_dv_in = 8'h82;
        push(7, 18'h00777);
        push(1, 18'h00111);
        tick();
        idle();
        tick();
        check("t3_first", 32'(bus.log_chan_out), 32'h7);
        tick();
        check("t3_second", 32'(bus.log_chan_out), 32'h1);
        tick();
        check("t3_idle", 32'(bus.log_dv_out), 32'h0);
        // rr_ptr now 2: ch2 must beat ch1.
        set_word(1, 18'h001A1);
        set_word(2, 18'h002A2);
        bus.osf_dv_in = 8'h06;
        push(2, 18'h002A2);
        push(1, 18'h001A1);
        tick();
        idle();
        tick();
        check("t3_ptr2_first", 32'(bus.log_chan_out), 32'h2);
        tick();
        check("t3_ptr2_second", 32'(bus.log_chan_out), 32'h1);
        tick();

        // ch2 overwritten while ch0/ch1 own the bus: one drop, newest word out.
        set_word(7, 18'h03777);
        bus.osf_dv_in = 8'h80;
        push(7, 18'h03777);
        tick();
        idle();
        tick();
        set_word(0, 18'h03000);
        set_word(1, 18'h03001);
        set_word(2, 18'h00011);
        bus.osf_dv_in = 8'h07;
        push(0, 18'h03000);
        push(1, 18'h03001);
        push(2, 18'h00022);
        tick();
        set_word(2, 18'h00022);
        bus.osf_dv_in = 8'h04;
        tick();
        idle();
        check("t4_drop_now", 32'(bus.drop_count_out), 32'h1);
        tick();
        tick();
        check("t4_ch2", 32'(bus.log_chan_out), 32'h2);
        check("t4_ch2_data", 32'(bus.log_data_out), 32'h22);
        tick();
        check("t4_idle", 32'(bus.log_dv_out), 32'h0);
        check("t4_drop", 32'(bus.drop_count_out), 32'h1);

        // Saturation: 1 + 9362 strobe cycles give 7*9362 = 0xFFFE drops.
        do_reset();
        check("t5_drop_clr", 32'(bus.drop_count_out), 32'h0);
        for (int k = 0; k < 8; k++) set_word(k, 18'(32'h200 + k));
        for (int i = 0; i < 9372; i++) push(i % 8, 18'(32'h200 + (i % 8)));
        bus.osf_dv_in = 8'hFF;
        repeat (9363) tick();
        check("t5_fffe", 32'(bus.drop_count_out), 32'hFFFE);
        tick();
        check("t5_sat1", 32'(bus.drop_count_out), 32'hFFFF);
        tick();
        check("t5_sat2", 32'(bus.drop_count_out), 32'hFFFF);
        idle();
        repeat (10) tick();
        check("t5_sat_hold", 32'(bus.drop_count_out), 32'hFFFF);
        check("t5_drained",  32'(exp_q.size()),       32'h0);

        // Disable ch4 while it is pending behind ch0..ch3.
        do_reset();
        for (int k = 0; k < 5; k++) set_word(k, 18'(32'h400 + k));
        for (int k = 0; k < 4; k++) push(k, 18'(32'h400 + k));
        bus.osf_dv_in = 8'h1F;
        tick();
        idle();
        host_wr(4, 1'b0, LOG_EN_RQST);
        tick();
        idle();
        check("t6_en", 32'(bus.log_en_out), 32'hEF);
        repeat (4) tick();
        check("t6_idle", 32'(bus.log_dv_out), 32'h0);
        set_word(4, 18'h04444);
        bus.osf_dv_in = 8'h10;
        tick();
        idle();
        tick();
        tick();
        check("t6_ignored", 32'(bus.log_dv_out),     32'h0);
        check("t6_no_drop", 32'(bus.drop_count_out), 32'h0);
        // Re-enable and strobe in the same cycle: capture sees new enable.
        host_wr(4, 1'b1, LOG_EN_RQST);
        set_word(4, 18'h04567);
        bus.osf_dv_in = 8'h10;
        push(4, 18'h04567);
        tick();
        idle();
        check("t6_reen", 32'(bus.log_en_out), 32'hFF);
        tick();
        check("t6_same_dv",   32'(bus.log_dv_out),   32'h1);
        check("t6_same_chan", 32'(bus.log_chan_out), 32'h4);
        tick();
        // Disable and strobe in the same cycle: strobe is ignored.
        host_wr(4, 1'b0, LOG_EN_RQST);
        bus.osf_dv_in = 8'h10;
        tick();
        idle();
        tick();
        tick();
        check("t6_dis_same", 32'(bus.log_dv_out), 32'h0);
        check("t6_en_ef",    32'(bus.log_en_out), 32'hEF);

        // Out-of-range channel and wrong address leave the mask alone.
        host_wr(9, 1'b0, LOG_EN_RQST);
        tick();
        idle();
        check("t7_chan9", 32'(bus.log_en_out), 32'hEF);
        host_wr(4, 1'b1, LOG_EN_RQST + 16'd1);
        tick();
        idle();
        check("t7_badaddr", 32'(bus.log_en_out), 32'hEF);
        host_wr(6, 1'b0, LOG_EN_RQST);
        tick();
        idle();
        check("t7_ch6", 32'(bus.log_en_out), 32'hAF);

        // Reset with channels pending discards them.
        for (int k = 0; k < 4; k++) set_word(k, 18'(32'h500 + k));
        bus.osf_dv_in = 8'h0F;
        push(0, 18'h00500);
        tick();
        set_word(1, 18'h05511);
        bus.osf_dv_in = 8'h02;
        tick();
        idle();
        check("t8_out0", 32'(bus.log_chan_out),   32'h0);
        check("t8_drop", 32'(bus.drop_count_out), 32'h1);
        rst = 1'b1;
        tick();
        check("t8_rst_dv",   32'(bus.log_dv_out),     32'h0);
        check("t8_rst_en",   32'(bus.log_en_out),     32'hFF);
        check("t8_rst_drop", 32'(bus.drop_count_out), 32'h0);
        check("t8_rst_chan", 32'(bus.log_chan_out),   32'h0);
        check("t8_rst_data", 32'(bus.log_data_out),   32'h0);
        rst = 1'b0;
        tick();
        check("t8_after_dv", 32'(bus.log_dv_out), 32'h0);
        repeat (5) tick();
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
